// File: rtl/seed_loader_if.sv
// Bundle of the seed loader's control, row data and board/indicator outputs.
// The master side drives buttons and switches; the slave side is the loader.
interface seed_loader_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int PW = $clog2(ROWS);

    logic                       next;
    logic                       prev;
    logic                       clear;
    logic                       restart;
    logic [COLS-1:0]            in;
    logic [ROWS-1:0][COLS-1:0]  board;
    logic [PW-1:0]              row_ptr;
    logic                       seed_valid;
    logic                       seed_done;
    logic [6:0]                 HEX0;

    modport master (
        output next, prev, clear, restart, in,
        input  board, row_ptr, seed_valid, seed_done, HEX0
    );

    modport slave (
        input  next, prev, clear, restart, in,
        output board, row_ptr, seed_valid, seed_done, HEX0
    );
endinterface

// File: rtl/seed_loader.sv
// Row-at-a-time Game-of-Life board seeder with prev/clear/restart editing.
// Optional macro SEED_DBUF_EN: rows land in a shadow array and the board updates atomically on completion.
module seed_loader #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic          clk,
    input  logic          reset,
    seed_loader_if.slave  ifc
);
    localparam int PW = $clog2(ROWS);
    localparam logic [PW-1:0] LAST_ROW = PW'(ROWS - 1);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     state_nx_s;
    logic [PW-1:0]              ptr_r;
    logic [PW-1:0]              ptr_nx_s;
    logic                       next_q_r;
    logic                       prev_q_r;
    logic                       next_edge_s;
    logic                       prev_edge_s;
    logic                       seed_valid_r;
    logic                       seed_done_r;
    logic                       done_nx_s;
    logic                       wr_en_s;
    logic                       clr_s;
    logic [ROWS-1:0][COLS-1:0]  board_r;
    logic [6:0]                 hex_s;

    // Seven-segment code (active low, gfedcba) for digits 1..9.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign next_edge_s = ifc.next & ~next_q_r;
    assign prev_edge_s = ifc.prev & ~prev_q_r;

    // Next-state logic: clear > restart > next > prev; losers are dropped.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        done_nx_s  = 1'b0;
        wr_en_s    = 1'b0;
        clr_s      = 1'b0;
        if (ifc.clear) begin
            state_nx_s = ST_LOAD;
            ptr_nx_s   = '0;
            clr_s      = 1'b1;
        end else if (ifc.restart) begin
            state_nx_s = ST_LOAD;
            ptr_nx_s   = '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (next_edge_s) begin
                        wr_en_s = 1'b1;
                        if (ptr_r == LAST_ROW) begin
                            state_nx_s = ST_FULL;
                            done_nx_s  = 1'b1;
                        end else begin
                            ptr_nx_s = ptr_r + PW'(1);
                        end
                    end else if (prev_edge_s) begin
                        if (ptr_r != '0) begin
                            ptr_nx_s = ptr_r - PW'(1);
                        end else begin
                            ptr_nx_s = ptr_r;
                        end
                    end else begin
                        ptr_nx_s = ptr_r;
                    end
                end
                ST_FULL: begin
                    state_nx_s = ST_FULL;
                end
                default: begin
                    state_nx_s = ST_LOAD;
                    ptr_nx_s   = '0;
                end
            endcase
        end
    end

    // Control state, status flags and button history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_LOAD;
            ptr_r        <= '0;
            seed_valid_r <= 1'b0;
            seed_done_r  <= 1'b0;
            // Held-high buttons through reset must not look like a fresh press.
            next_q_r     <= 1'b1;
            prev_q_r     <= 1'b1;
        end else begin
            state_r      <= state_nx_s;
            ptr_r        <= ptr_nx_s;
            seed_valid_r <= (state_nx_s == ST_FULL);
            seed_done_r  <= done_nx_s;
            next_q_r     <= ifc.next;
            prev_q_r     <= ifc.prev;
        end
    end

`ifdef SEED_DBUF_EN
    logic [ROWS-1:0][COLS-1:0] shadow_r;
    logic [ROWS-1:0][COLS-1:0] merged_s;

    // Shadow contents including the row being written this cycle.
    always_comb begin
        merged_s        = shadow_r;
        merged_s[ptr_r] = ifc.in;
    end

    // Rows collect in the shadow; the board takes them all on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r <= '0;
            board_r  <= '0;
        end else if (clr_s) begin
            shadow_r <= '0;
            board_r  <= '0;
        end else if (wr_en_s) begin
            shadow_r[ptr_r] <= ifc.in;
            if (done_nx_s) begin
                board_r <= merged_s;
            end else begin
                board_r <= board_r;
            end
        end else begin
            shadow_r <= shadow_r;
            board_r  <= board_r;
        end
    end
`else
    // Direct row-by-row board writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            board_r <= '0;
        end else if (clr_s) begin
            board_r <= '0;
        end else if (wr_en_s) begin
            board_r[ptr_r] <= ifc.in;
        end else begin
            board_r <= board_r;
        end
    end
`endif

    // Row indicator: 1-based row number while loading, 'd' once full.
    always_comb begin
        hex_s = 7'b1111111;
        if (state_r == ST_FULL) begin
            hex_s = 7'b0100001;
        end else begin
            hex_s = seg_digit(4'(ptr_r) + 4'd1);
        end
    end

    assign ifc.board      = board_r;
    assign ifc.row_ptr    = ptr_r;
    assign ifc.seed_valid = seed_valid_r;
    assign ifc.seed_done  = seed_done_r;
    assign ifc.HEX0       = hex_s;
endmodule

// File: tb/tb_seed_loader.sv
// Scoreboard bench for seed_loader: directed scenarios plus random button/switch activity,
// each cycle's expected outputs come from a behavioural model and are checked by a monitor.
module tb_seed_loader;
`ifdef SEED_DBUF_EN
    localparam int ROWS = 4;
    localparam int COLS = 5;
`else
    localparam int ROWS = 8;
    localparam int COLS = 8;
`endif
    localparam int PW = $clog2(ROWS);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seed_loader_if #(.ROWS(ROWS), .COLS(COLS)) ifc ();

    seed_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc.slave)
    );

    typedef struct packed {
        logic [ROWS-1:0][COLS-1:0] board;
        logic [PW-1:0]             ptr;
        logic                      valid;
        logic                      done;
        logic [6:0]                hex;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    logic [COLS-1:0] m_board  [ROWS];
    logic [COLS-1:0] m_shadow [ROWS];
    int              m_ptr;
    bit              m_full;
    bit              m_done;
    bit              m_nq;
    bit              m_pq;
    logic [6:0]      digit_codes [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // One clock of stimulus; the model advances and the expected outcome is queued.
    task automatic step(input bit rst, input bit nx, input bit pv, input bit clr,
                        input bit rs, input logic [COLS-1:0] din);
        exp_t e;
        bit   ne;
        bit   pe;
        @(negedge clk);
        reset       = rst;
        ifc.next    = nx;
        ifc.prev    = pv;
        ifc.clear   = clr;
        ifc.restart = rs;
        ifc.in      = din;
        m_done = 1'b0;
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                m_board[r]  = '0;
                m_shadow[r] = '0;
            end
            m_ptr  = 0;
            m_full = 1'b0;
            m_nq   = 1'b1;
            m_pq   = 1'b1;
        end else begin
            ne = nx && !m_nq;
            pe = pv && !m_pq;
            if (clr) begin
                for (int r = 0; r < ROWS; r++) begin
                    m_board[r]  = '0;
                    m_shadow[r] = '0;
                end
                m_ptr  = 0;
                m_full = 1'b0;
            end else if (rs) begin
                m_ptr  = 0;
                m_full = 1'b0;
            end else if (!m_full && ne) begin
`ifdef SEED_DBUF_EN
                m_shadow[m_ptr] = din;
                if (m_ptr == ROWS - 1) begin
                    for (int r = 0; r < ROWS; r++) m_board[r] = m_shadow[r];
                    m_full = 1'b1;
                    m_done = 1'b1;
                end else m_ptr++;
`else
                m_board[m_ptr] = din;
                if (m_ptr == ROWS - 1) begin
                    m_full = 1'b1;
                    m_done = 1'b1;
                end else m_ptr++;
`endif
            end else if (!m_full && pe) begin
                if (m_ptr > 0) m_ptr--;
            end
            m_nq = nx;
            m_pq = pv;
        end
        for (int r = 0; r < ROWS; r++) e.board[r] = m_board[r];
        e.ptr   = PW'(m_ptr);
        e.valid = m_full;
        e.done  = m_done;
        e.hex   = m_full ? 7'b0100001 : digit_codes[m_ptr];
        exp_q.push_back(e);
    endtask

    task automatic press_next(input logic [COLS-1:0] din);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, din);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, din);
    endtask

    task automatic press_prev();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: compares every presented output cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("board",      64'(ifc.board),      64'(e.board));
                chk("row_ptr",    64'(ifc.row_ptr),    64'(e.ptr));
                chk("seed_valid", 64'(ifc.seed_valid), 64'(e.valid));
                chk("seed_done",  64'(ifc.seed_done),  64'(e.done));
                chk("HEX0",       64'(ifc.HEX0),       64'(e.hex));
            end
        end
    end

    initial begin
        bit nl;
        bit pl;
        digit_codes[0] = 7'b1111001; digit_codes[1] = 7'b0100100; digit_codes[2] = 7'b0110000;
        digit_codes[3] = 7'b0011001; digit_codes[4] = 7'b0010010; digit_codes[5] = 7'b0000010;
        digit_codes[6] = 7'b1111000; digit_codes[7] = 7'b0000000; digit_codes[8] = 7'b0010000;
        reset = 1'b1; ifc.next = 1'b1; ifc.prev = 1'b0;
        ifc.clear = 1'b0; ifc.restart = 1'b0; ifc.in = '0;

        // Reset with next held high: release gives no write.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, COLS'(8'h3C));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, COLS'(8'h3C));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, COLS'(8'h3C));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, COLS'(8'h3C));
        idle();
        press_next(COLS'(8'h3C));

        // Full load with alternating patterns, then an extra press while full.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int r = 0; r < ROWS + 1; r++) press_next(r[0] ? COLS'(8'hAA) : COLS'(8'h55));
        idle();

        // Restart from FULL keeps the board; clear then empties it.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // Three rows, back twice, overwrite row 1; then prev saturation at 0.
        for (int r = 0; r < 3; r++) press_next(COLS'(r + 1));
        press_prev();
        press_prev();
        press_next(COLS'(8'hFF));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        press_prev();

        // Same-cycle collisions: next+clear, next+prev, restart+next.
        press_next(COLS'(8'h11));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, COLS'(8'h22));
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, COLS'(8'h33));
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, COLS'(8'h44));
        idle();

        // Random activity including mid-run resets.
        nl = 1'b0;
        pl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) nl = ~nl;
            if ($urandom_range(0, 4) == 0) pl = ~pl;
            step(($urandom_range(0, 200) == 0), nl, pl,
                 ($urandom_range(0, 70) == 0), ($urandom_range(0, 40) == 0),
                 COLS'($urandom));
        end
        idle();
        idle();

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/seed_loader.md
Name: seed_loader

Overview:
- Parameterised successor to the 8x8 board seeder.
- Loads an initial ROWS x COLS Game-of-Life pattern one row at a time from switch input, advancing on a user "next" pulse.
- Adds prev/clear/restart editing, a load-complete handshake, and a 7-seg row indicator.
- Feeds the generation engine, which consumes board once seed_valid is high.

Parameters:
- ROWS, 8: board rows; legal range 2..9.
- COLS, 8: board columns (row width); legal range 1..32.

Ports:
- clk  in  1  system clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- next  in  1  level from debounced/synchronised button; rising edge writes current row and advances.
- prev  in  1  level; rising edge steps row pointer back without writing.
- clear  in  1  one-cycle strobe; zeroes board and restarts loading.
- restart  in  1  one-cycle strobe; restarts loading, board retained.
- in  in  COLS  row data from switches.
- board  out  ROWS x COLS (packed [ROWS-1:0][COLS-1:0])  seeded pattern; board[r] is row r.
- row_ptr  out  $clog2(ROWS)  index of the row the next write targets.
- seed_valid  out  1  high while the board is fully loaded (FULL state).
- seed_done  out  1  one-cycle pulse on entry to FULL.
- HEX0  out  7  active-low segments gfedcba.

Behaviour:
- Edge detect: registers next_q and prev_q; reset value 1, so a button held through reset gives no edge. Edge = level & ~level_q.
- If next is 0 at edge k-1 and 1 at edge k, the action happens at edge k and is visible after edge k. No further action until next returns low.
- FSM states: LOAD, FULL. Reset -> LOAD.
- Reset values: row_ptr=0, board all 0, seed_valid=0, seed_done=0.
- LOAD, next edge: board[row_ptr] <= in.
  - row_ptr < ROWS-1: row_ptr increments.
  - row_ptr == ROWS-1: -> FULL; seed_done=1 for that one cycle; row_ptr stays ROWS-1.
- LOAD, prev edge: row_ptr decrements, saturating at 0; board unchanged.
- LOAD, next and prev edges in the same cycle: next wins, prev ignored.
- FULL: next and prev ignored; seed_valid=1; board held stable.
- restart (any state): -> LOAD, row_ptr=0, seed_valid=0, board retained; next edges then overwrite rows in order.
- clear (any state): -> LOAD, row_ptr=0, board all 0, seed_valid=0.
- Priority in one cycle: reset > clear > restart > next > prev. A lower-priority edge in the same cycle is discarded, not deferred.
- seed_done is never asserted in a cycle where clear/restart/reset is taken.
- HEX0 is combinational:
  - LOAD: shows row_ptr+1 as a digit (1..9). Codes: 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - FULL: shows 'd' = 0100001.
- Width rule: in is exactly COLS bits; no truncation or extension.

Optional Feature:
- Macro: SEED_DBUF_EN.
- Defined:
  - next writes go to an internal shadow array; board stays unchanged during LOAD.
  - On the cycle FULL is entered, board <= shadow with the final row included; board updates atomically with seed_done.
  - clear zeroes both shadow and board.
  - restart retains both.
- Not defined: board is written row by row directly, as above.

Test Plan:
- Reset with next held high, then release reset -> no write, row_ptr=0, HEX0=1111001; next low->high writes in to row 0, row_ptr=1.
- ROWS=8, COLS=8: 8 next edges with in alternating 8'h55/8'hAA -> board rows 0..7 = 55,AA,55,AA,55,AA,55,AA; seed_done high exactly 1 cycle at 8th edge; seed_valid=1; HEX0=0100001; 9th edge leaves board unchanged.
- Load 3 rows, prev edge twice, next with in=8'hFF -> row 1 = FF, row_ptr=2; prev at row_ptr=0 stays 0.
- FULL, assert restart -> seed_valid=0, row_ptr=0, board unchanged; assert clear -> board all 0.
- Same cycle: next edge + clear -> board all 0, row_ptr=0, no write; next + prev edges -> write and increment only.
- SEED_DBUF_EN defined, ROWS=4, COLS=5: board stays 0 through first 3 next edges; on 4th, all 4 rows appear together with seed_done.
